// File: rtl/fpu_instr_encoder.sv
// Encodes decoded FPU commands into RV64D OP-FP instruction words and queues them in a FIFO.
// Optional statistics counters are enabled with the FPU_ENC_STATS_EN macro.
module fpu_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_op,
  input  logic [4:0]                 cmd_rd,
  input  logic [4:0]                 cmd_rs1,
  input  logic [4:0]                 cmd_rs2,
  input  logic [2:0]                 cmd_rm,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [31:0]                instr,
  output logic                       bad_op,
  output logic [$clog2(DEPTH):0]     fifo_level
`ifdef FPU_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0]           issued_cnt,
  output logic [CNT_W-1:0]           dropped_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("fpu_instr_encoder: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  function automatic logic op_is_valid(input logic [4:0] op);
    return (op <= 5'd6);
  endfunction

  // Reserved rounding modes 101/110 fall back to dynamic rounding.
  function automatic logic [2:0] fix_rm(input logic [2:0] rm);
    if (rm == 3'b101 || rm == 3'b110) return 3'b111;
    return rm;
  endfunction

  function automatic logic [31:0] encode(
    input logic [4:0] op,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [2:0] rm
  );
    logic [6:0] funct7;
    logic [4:0] rs2_f;
    funct7 = 7'b0000000;
    rs2_f  = rs2;
    case (op)
      5'd0: funct7 = 7'b0000001;
      5'd1: funct7 = 7'b0000101;
      5'd2: funct7 = 7'b0001001;
      5'd3: funct7 = 7'b0001101;
      5'd4: begin funct7 = 7'b0101101; rs2_f = 5'b00000; end
      5'd5: begin funct7 = 7'b1100001; rs2_f = 5'b00010; end
      5'd6: begin funct7 = 7'b1101001; rs2_f = 5'b00010; end
      default: begin funct7 = 7'b0000000; rs2_f = 5'b00000; end
    endcase
    return {funct7, rs2_f, rs1, fix_rm(rm), rd, OPCODE_OP_FP};
  endfunction

  logic [31:0]      word_p0;
  logic             vld_p0;
  logic             op_ok_p0;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [31:0]      mem [DEPTH];

  assign cmd_ready   = (level != LVL_W'(DEPTH));
  assign vld_p0      = cmd_valid && cmd_ready;
  assign op_ok_p0    = op_is_valid(cmd_op);
  assign word_p0     = encode(cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_rm);
  assign push        = vld_p0 && op_ok_p0;
  assign instr_valid = (level != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? mem[rd_ptr] : 32'h0;
  assign fifo_level  = level;

  // Stage p0 -> FIFO storage: data written without reset, control reset below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      bad_op <= 1'b0;
    end else begin
      bad_op <= vld_p0 && !op_ok_p0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef FPU_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (pop && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
      if (vld_p0 && !op_ok_p0 && dropped_cnt != '1) dropped_cnt <= dropped_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_instr_encoder.sv
// Directed bench for fpu_instr_encoder: encodings, backpressure, invalid ops, streaming, reset.
module tb_fpu_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [2:0]  cmd_rm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        bad_op;
  logic [2:0]  fifo_level;
`ifdef FPU_ENC_STATS_EN
  logic [15:0] issued_cnt;
  logic [15:0] dropped_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fpu_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rm(cmd_rm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .bad_op(bad_op), .fifo_level(fifo_level)
`ifdef FPU_ENC_STATS_EN
    , .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] rm);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rm = rm;
  endtask

  // fadd.d with rs1=2, rs2=3, rm=111 and a variable rd
  function automatic logic [31:0] fadd_w(input logic [4:0] rd);
    return 32'h02317053 | ({27'd0, rd} << 7);
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b0;
    set_cmd(5'd0, 5'd0, 5'd0, 5'd0, 3'd0);
    #2;
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_bad_op", {31'd0, bad_op}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single fadd.d
    set_cmd(5'd0, 5'd1, 5'd2, 5'd3, 3'b111); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h023170d3);
    chk("t1_level", {29'd0, fifo_level}, 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t1_empty_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_empty_instr", instr, 32'h0);

    // 2: sqrt/convert forms, drained in order
    cmd_valid = 1'b1;
    set_cmd(5'd4, 5'd23, 5'd3, 5'd31, 3'b111); tick();
    set_cmd(5'd5, 5'd19, 5'd11, 5'd7, 3'b111); tick();
    set_cmd(5'd6, 5'd27, 5'd12, 5'd9, 3'b111); tick();
    cmd_valid = 1'b0;
    chk("t2_level", {29'd0, fifo_level}, 32'd3);
    chk("t2_w0", instr, 32'h5a01fbd3);
    instr_ready = 1'b1;
    tick(); chk("t2_w1", instr, 32'hc225f9d3);
    tick(); chk("t2_w2", instr, 32'hd2267dd3);
    tick(); instr_ready = 1'b0;
    chk("t2_drained", {29'd0, fifo_level}, 32'd0);

    // 3: fill, hold fifth command, accept only after a pop
    cmd_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_cmd(5'd0, 5'(i), 5'd2, 5'd3, 3'b111);
      tick();
    end
    set_cmd(5'd0, 5'd5, 5'd2, 5'd3, 3'b111);
    chk("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t3_full_level", {29'd0, fifo_level}, 32'd4);
    tick();
    chk("t3_held_level", {29'd0, fifo_level}, 32'd4);
    chk("t3_stable_head", instr, fadd_w(5'd1));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t3_pop_no_accept", {29'd0, fifo_level}, 32'd3);
    chk("t3_ready_again", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t3_fifth_accepted", {29'd0, fifo_level}, 32'd4);
    instr_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("t3_order%0d", i), instr, fadd_w(5'(i)));
      tick();
    end
    instr_ready = 1'b0;
    chk("t3_drained", {29'd0, fifo_level}, 32'd0);

    // 4: invalid op
    set_cmd(5'd7, 5'd1, 5'd1, 5'd1, 3'b000); cmd_valid = 1'b1;
    chk("t4_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("t4_bad_op_hi", {31'd0, bad_op}, 32'd1);
    chk("t4_level", {29'd0, fifo_level}, 32'd0);
    chk("t4_no_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t4_bad_op_lo", {31'd0, bad_op}, 32'd0);

    // 5: reserved rounding mode substitution
    set_cmd(5'd1, 5'd11, 5'd20, 5'd13, 3'b101); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t5_instr", instr, 32'h0ada75d3);
    instr_ready = 1'b1;
    tick();

    // 6: full-rate streaming, then asynchronous reset mid-stream
    cmd_valid = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      set_cmd(5'd0, 5'(i), 5'd2, 5'd3, 3'b111);
      tick();
      chk($sformatf("t6_level%0d", i), {29'd0, fifo_level}, 32'd1);
      chk($sformatf("t6_word%0d", i), instr, fadd_w(5'(i)));
    end
`ifdef FPU_ENC_STATS_EN
    chk("stats_issued", {16'd0, issued_cnt}, 32'd15);
    chk("stats_dropped", {16'd0, dropped_cnt}, 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("t6_rst_instr", instr, 32'h0);
`ifdef FPU_ENC_STATS_EN
    chk("stats_rst_issued", {16'd0, issued_cnt}, 32'd0);
    chk("stats_rst_dropped", {16'd0, dropped_cnt}, 32'd0);
`endif
    cmd_valid = 1'b0;
    instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_level", {29'd0, fifo_level}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_instr_encoder.md
Name: fpu_instr_encoder

Overview:
Sequential encoder, the inverse of the FPU control decoder. It accepts decoded FPU commands (fpu_op code plus register indices and rounding mode) over a valid/ready handshake. It assembles the 32-bit RV64D OP-FP instruction words, buffers them in a small FIFO, and presents them over a second valid/ready handshake. It is used by the FP self-test sequencer and bench stimulus to produce instruction words that the decoder consumes.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  encoder can accept a command.
cmd_op  input  5  fpu_op code: 0 fadd.d, 1 fsub.d, 2 fmul.d, 3 fdiv.d, 4 fsqrt.d, 5 fcvt.l.d, 6 fcvt.d.l; all other values invalid.
cmd_rd  input  5  destination register index.
cmd_rs1  input  5  source register 1 index.
cmd_rs2  input  5  source register 2 index.
cmd_rm  input  3  rounding mode.
instr_valid  output  1  FIFO head holds an instruction word.
instr_ready  input  1  consumer takes the head entry.
instr  output  32  encoded instruction word at the FIFO head.
bad_op  output  1  one-cycle pulse: an invalid cmd_op was consumed.
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0): read/write pointers and occupancy cleared; instr_valid=0, instr=0, bad_op=0, fifo_level=0, cmd_ready=1. Reset mid-operation discards all buffered entries.
- Handshake rules:
  - Accept occurs when cmd_valid && cmd_ready.
  - Pop occurs when instr_valid && instr_ready.
  - cmd_ready = (fifo_level != DEPTH), combinational from the registered level.
  - cmd_ready does not depend on instr_ready; a full FIFO blocks accept even in a cycle that pops.
- Encoding fields:
  - opcode[6:0] = 1010011.
  - rd=[11:7], rm=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- funct7 / rs2 by op:
  - op0: 0000001, cmd_rs2.
  - op1: 0000101, cmd_rs2.
  - op2: 0001001, cmd_rs2.
  - op3: 0001101, cmd_rs2.
  - op4: 0101101, rs2 forced to 00000.
  - op5: 1100001, rs2 forced to 00010.
  - op6: 1101001, rs2 forced to 00010.
- Rounding mode: reserved cmd_rm values 101 and 110 are replaced by 111 (dynamic); all other values pass through unchanged.
- Invalid op: the command is accepted (cmd_ready obeyed) but nothing is written to the FIFO; bad_op goes high for exactly one cycle, the cycle after the accept.
- Latency: a word accepted in cycle N is visible as instr_valid=1 with the correct instr in cycle N+1. There is no combinational path from cmd_* to instr_*.
- Output when empty: instr_valid=0 and instr=32'h0 (head is not exposed).
- Ordering and occupancy:
  - Strict FIFO order.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves fifo_level unchanged and keeps the data intact.
  - instr and instr_valid are stable while instr_valid && !instr_ready.

Optional Feature:
Macro FPU_ENC_STATS_EN.
- When defined, the block adds outputs issued_cnt[CNT_W-1:0] and dropped_cnt[CNT_W-1:0].
  - issued_cnt increments on each pop.
  - dropped_cnt increments on each invalid-op accept.
  - Both saturate at all-ones, reset to 0, and update in the cycle after the event.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then op0, rd1, rs1=2, rs2=3, rm=111 -> next cycle instr_valid=1, instr=32'h023170d3, fifo_level=1.
2. Push op4 (rd23, rs1=3, rs2=31, rm=111), op5 (rd19, rs1=11), op6 (rd27, rs1=12) with instr_ready=0 -> then drain in order 32'h5a01fbd3, 32'hc225f9d3, 32'hd2267dd3 (op4's rs2 is forced to 0).
3. Fill DEPTH=4 with instr_ready=0 -> cmd_ready=0, fifo_level=4. Fifth command is held; it is accepted only the cycle after a pop.
4. cmd_op=7 with cmd_valid=1 -> accepted, bad_op pulses one cycle, fifo_level unchanged, no instr_valid.
5. op1 (rd11, rs1=20, rs2=13) with cmd_rm=101 -> instr=32'h0ada75d3 (rm substituted with 111).
6. Continuous push and pop at full rate with instr_ready=1 -> level stays 1 and the words appear in order. Assert rst_n=0 mid-stream -> instr_valid=0 immediately and level=0. With FPU_ENC_STATS_EN, the counters match the number of pops and drops.
